// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
//  Module   : program_loader
//  Purpose  : Boot-time loader placed directly upstream of the CPU. It takes
//             a byte stream over a valid/ready handshake and assembles 32-bit
//             little-endian instruction words. Each word is written into
//             instruction memory, and the XOR checksum of the payload is
//             verified. Only then is the CPU released from reset through
//             start.
//
//             Stream format:
//               LEN_LO, LEN_HI   16-bit word count N, little-endian
//               4*N bytes        payload, each word LSB first
//               CSUM             XOR of all payload bytes
//
//  Ports    : clk         in   1   system clock, rising edge
//             rst         in   1   synchronous active-high reset
//             load_en     in   1   begin-load request (sampled in IDLE/ERR)
//             byte_valid  in   1   byte_data holds a valid byte
//             byte_data   in   8   stream byte
//             byte_ready  out  1   loader accepts a byte this cycle
//             mem_we      out  1   instruction-memory write strobe
//             mem_addr    out  32  byte address of the word being written
//             mem_wdata   out  32  assembled instruction word
//             start       out  1   CPU run enable (0 holds CPU in reset)
//             done        out  1   image loaded and checksum valid
//             error       out  1   length or checksum failure
//             word_count  out  16  words written in the current load
//
//  Revision : 1.0  initial release
// ============================================================================
module program_loader #(
    parameter int          MAX_WORDS = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_en,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        start,
    output logic        done,
    output logic        error,
    output logic [15:0] word_count
);

    localparam logic [2:0] c_st_idle = 3'd0;
    localparam logic [2:0] c_st_len0 = 3'd1;
    localparam logic [2:0] c_st_len1 = 3'd2;
    localparam logic [2:0] c_st_data = 3'd3;
    localparam logic [2:0] c_st_csum = 3'd4;
    localparam logic [2:0] c_st_run  = 3'd5;
    localparam logic [2:0] c_st_err  = 3'd6;

    // One extra bit so a length of 0xFFFF compares correctly against any
    // MAX_WORDS up to 65535.
    localparam logic [16:0] c_max_words = 17'(MAX_WORDS);

    logic [2:0]  r_state;
    logic [2:0]  w_next_state;

    logic [15:0] r_len;
    logic [7:0]  r_acc;
    logic [1:0]  r_idx;
    logic [23:0] r_buf;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [15:0] r_word_count;
    logic        r_start;
    logic        r_error;

    logic        w_byte_ready;
    logic        w_accept;
    logic        w_load_req;
    logic [15:0] w_len_full;
    logic        w_oversize;
    logic        w_last_word;

    assign w_byte_ready = (r_state == c_st_len0) || (r_state == c_st_len1) ||
                          (r_state == c_st_data) || (r_state == c_st_csum);
    assign w_accept     = byte_valid && w_byte_ready;
    assign w_load_req   = load_en && ((r_state == c_st_idle) || (r_state == c_st_err));

    // Length as it stands once the high byte currently on the bus lands.
    assign w_len_full   = {byte_data, r_len[7:0]};
    assign w_oversize   = {1'b0, w_len_full} > c_max_words;

    // word_count still holds the number of words written before the word
    // now completing, so this word is the last when count+1 reaches N.
    assign w_last_word  = (r_word_count + 16'd1) == r_len;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle: begin
                if (load_en) w_next_state = c_st_len0;
            end
            c_st_len0: begin
                if (w_accept) w_next_state = c_st_len1;
            end
            c_st_len1: begin
                if (w_accept) begin
                    if (w_oversize)              w_next_state = c_st_err;
                    else if (w_len_full == 16'd0) w_next_state = c_st_csum;
                    else                          w_next_state = c_st_data;
                end
            end
            c_st_data: begin
                if (w_accept && (r_idx == 2'd3) && w_last_word) w_next_state = c_st_csum;
            end
            c_st_csum: begin
                if (w_accept) begin
                    w_next_state = (byte_data == r_acc) ? c_st_run : c_st_err;
                end
            end
            c_st_run: begin
                w_next_state = c_st_run;   // sticky until rst
            end
            c_st_err: begin
                if (load_en) w_next_state = c_st_len0;
            end
            default: begin
                w_next_state = c_st_idle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: length capture, word assembly, checksum, memory write
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_len        <= 16'd0;
            r_acc        <= 8'd0;
            r_idx        <= 2'd0;
            r_buf        <= 24'd0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= 32'd0;
            r_mem_wdata  <= 32'd0;
            r_word_count <= 16'd0;
            r_start      <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_mem_we <= 1'b0;
            // Flags follow the state being entered, so they are valid in
            // the first cycle of RUN/ERR and drop as soon as ERR is left.
            r_start  <= (w_next_state == c_st_run);
            r_error  <= (w_next_state == c_st_err);

            if (w_load_req) begin
                r_len        <= 16'd0;
                r_acc        <= 8'd0;
                r_idx        <= 2'd0;
                r_word_count <= 16'd0;
            end

            if (w_accept) begin
                case (r_state)
                    c_st_len0: r_len[7:0]  <= byte_data;
                    c_st_len1: r_len[15:8] <= byte_data;
                    c_st_data: begin
                        r_acc <= r_acc ^ byte_data;
                        r_idx <= r_idx + 2'd1;
                        case (r_idx)
                            2'd0: r_buf[7:0]   <= byte_data;
                            2'd1: r_buf[15:8]  <= byte_data;
                            2'd2: r_buf[23:16] <= byte_data;
                            default: begin
                                // Fourth byte: issue the write in the next
                                // cycle, overlapping the next word's first byte.
                                r_mem_we     <= 1'b1;
                                r_mem_wdata  <= {byte_data, r_buf};
                                r_mem_addr   <= BASE_ADDR + {14'd0, r_word_count, 2'b00};
                                r_word_count <= r_word_count + 16'd1;
                            end
                        endcase
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign byte_ready = w_byte_ready;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign start      = r_start;
    assign done       = r_start;
    assign error      = r_error;
    assign word_count = r_word_count;

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_program_loader
//  Purpose  : Self-checking bench for program_loader. Expected memory writes
//             are queued as words are sent and matched against each mem_we
//             pulse; status outputs are compared at directed points.
//  Revision : 1.0  initial release
// ============================================================================
module tb_program_loader;

    localparam int          MAX_WORDS = 4;
    localparam logic [31:0] BASE_ADDR = 32'h0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_en = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        start;
    logic        done;
    logic        error;
    logic [15:0] word_count;

    program_loader #(
        .MAX_WORDS (MAX_WORDS),
        .BASE_ADDR (BASE_ADDR)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load_en    (load_en),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .start      (start),
        .done       (done),
        .error      (error),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [15:0] wc;
    } wr_t;

    wr_t        sb[$];
    int         widx = 0;
    logic [7:0] csum = 8'h00;
    int         last4_cyc = -1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every write strobe must match the oldest queued word, and
    // arrive in the cycle right after that word's last byte was accepted.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (sb.size() == 0) begin
                chk("we_unexpected", {31'd0, mem_we}, 32'd0);
            end else begin
                wr_t e;
                e = sb.pop_front();
                chk("we_addr", mem_addr, e.addr);
                chk("we_data", mem_wdata, e.data);
                chk("we_word_count", {16'd0, word_count}, {16'd0, e.wc});
                chk("we_latency", cyc, last4_cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic reset_dut();
        rst = 1'b1;
        load_en = 1'b0;
        byte_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic start_load(input bit hold);
        widx = 0;
        csum = 8'h00;
        load_en = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) load_en = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int  n;
        bit  rdy;
        if (gaps) begin
            int g;
            g = $urandom_range(0, 2);
            repeat (g) begin
                @(posedge clk);
                #1;
            end
        end
        byte_valid = 1'b1;
        byte_data  = b;
        n   = 0;
        rdy = 1'b0;
        while (!rdy && n < 50) begin
            @(negedge clk);
            rdy = byte_ready;
            @(posedge clk);
            #1;
            n++;
        end
        chk("byte_accept", {31'd0, rdy}, 32'd1);
        byte_valid = 1'b0;
    endtask

    task automatic send_len(input logic [15:0] n, input bit gaps);
        send_byte(n[7:0], gaps);
        send_byte(n[15:8], gaps);
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps);
        wr_t e;
        e.addr = BASE_ADDR + 32'(4 * widx);
        e.data = w;
        e.wc   = 16'(widx + 1);
        sb.push_back(e);
        widx++;
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8], gaps);
            csum = csum ^ w[8*i +: 8];
        end
        last4_cyc = cyc;
    endtask

    task automatic send_csum(input logic [7:0] flip, input bit gaps);
        send_byte(csum ^ flip, gaps);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_byte_ready"}, {31'd0, byte_ready}, 32'd0);
        chk({tag, "_mem_we"},     {31'd0, mem_we},     32'd0);
        chk({tag, "_start"},      {31'd0, start},      32'd0);
        chk({tag, "_done"},       {31'd0, done},       32'd0);
        chk({tag, "_error"},      {31'd0, error},      32'd0);
        chk({tag, "_mem_addr"},   mem_addr,            32'd0);
        chk({tag, "_mem_wdata"},  mem_wdata,           32'd0);
        chk({tag, "_word_count"}, {16'd0, word_count}, 32'd0);
    endtask

    initial begin
        int t0;

        // ---------------- reset state ----------------
        reset_dut();
        @(negedge clk);
        check_idle("reset");

        // ---------------- normal 2-word load, gap-free ----------------
        start_load(1'b0);
        t0 = cyc;
        send_len(16'd2, 1'b0);
        send_word(32'h00A00513, 1'b0);
        send_word(32'h00500593, 1'b0);
        send_csum(8'h00, 1'b0);
        chk("norm_throughput", cyc - t0, 32'd11);
        @(negedge clk);
        chk("norm_start", {31'd0, start}, 32'd1);
        chk("norm_done", {31'd0, done}, 32'd1);
        chk("norm_error", {31'd0, error}, 32'd0);
        chk("norm_word_count", {16'd0, word_count}, 32'd2);
        chk("norm_ready", {31'd0, byte_ready}, 32'd0);
        chk("norm_sb_empty", sb.size(), 32'd0);

        // ---------------- bad checksum, then recovery ----------------
        reset_dut();
        start_load(1'b0);
        send_len(16'd2, 1'b0);
        send_word(32'h00A00513, 1'b0);
        send_word(32'h00500593, 1'b0);
        send_csum(8'h01, 1'b0);
        @(negedge clk);
        chk("badcs_error", {31'd0, error}, 32'd1);
        chk("badcs_start", {31'd0, start}, 32'd0);
        chk("badcs_ready", {31'd0, byte_ready}, 32'd0);
        chk("badcs_word_count", {16'd0, word_count}, 32'd2);
        chk("badcs_sb_empty", sb.size(), 32'd0);
        @(posedge clk);
        #1;
        start_load(1'b0);
        send_len(16'd1, 1'b0);
        send_word(32'h12345678, 1'b0);
        send_csum(8'h00, 1'b0);
        @(negedge clk);
        chk("retry_start", {31'd0, start}, 32'd1);
        chk("retry_error", {31'd0, error}, 32'd0);
        chk("retry_word_count", {16'd0, word_count}, 32'd1);
        chk("retry_sb_empty", sb.size(), 32'd0);

        // ---------------- oversize length, then N = MAX_WORDS ----------------
        reset_dut();
        start_load(1'b0);
        send_len(16'd5, 1'b0);
        @(negedge clk);
        chk("over_error", {31'd0, error}, 32'd1);
        chk("over_ready", {31'd0, byte_ready}, 32'd0);
        chk("over_word_count", {16'd0, word_count}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        start_load(1'b0);
        send_len(16'd4, 1'b0);
        send_word(32'h00000093, 1'b0);
        send_word(32'h00100113, 1'b0);
        send_word(32'h00208193, 1'b0);
        send_word(32'h0000006F, 1'b0);
        send_csum(8'h00, 1'b0);
        @(negedge clk);
        chk("max_start", {31'd0, start}, 32'd1);
        chk("max_word_count", {16'd0, word_count}, 32'd4);
        chk("max_sb_empty", sb.size(), 32'd0);

        // ---------------- zero length ----------------
        reset_dut();
        start_load(1'b0);
        send_len(16'd0, 1'b0);
        send_csum(8'h00, 1'b0);
        @(negedge clk);
        chk("zero_start", {31'd0, start}, 32'd1);
        chk("zero_error", {31'd0, error}, 32'd0);
        chk("zero_word_count", {16'd0, word_count}, 32'd0);
        reset_dut();
        start_load(1'b0);
        send_len(16'd0, 1'b0);
        send_byte(8'h01, 1'b0);
        @(negedge clk);
        chk("zero_bad_error", {31'd0, error}, 32'd1);
        chk("zero_bad_start", {31'd0, start}, 32'd0);

        // ---------------- gaps with load_en held high ----------------
        reset_dut();
        start_load(1'b1);
        send_len(16'd3, 1'b1);
        send_word(32'hCAFEF00D, 1'b1);
        send_word(32'h0BADBEEF, 1'b1);
        send_word(32'h80000001, 1'b1);
        send_csum(8'h00, 1'b1);
        @(negedge clk);
        chk("gap_start", {31'd0, start}, 32'd1);
        repeat (5) @(negedge clk);
        chk("gap_run_sticky", {31'd0, start}, 32'd1);
        chk("gap_run_ready", {31'd0, byte_ready}, 32'd0);
        chk("gap_word_count", {16'd0, word_count}, 32'd3);
        chk("gap_sb_empty", sb.size(), 32'd0);
        load_en = 1'b0;

        // ---------------- reset mid-payload ----------------
        reset_dut();
        start_load(1'b0);
        send_len(16'd2, 1'b0);
        send_word(32'hA5A55A5A, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_idle("midrst");
        repeat (8) @(negedge clk);
        chk("midrst_start_held", {31'd0, start}, 32'd0);
        chk("midrst_sb_empty", sb.size(), 32'd0);
        @(posedge clk);
        #1;
        start_load(1'b0);
        send_len(16'd1, 1'b0);
        send_word(32'h00000013, 1'b0);
        send_csum(8'h00, 1'b0);
        @(negedge clk);
        chk("midrst_reload_start", {31'd0, start}, 32'd1);
        chk("midrst_reload_count", {16'd0, word_count}, 32'd1);
        chk("midrst_reload_sb", sb.size(), 32'd0);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
